// File: rtl/rx_word_packer_pkg.sv
// rx_word_packer_pkg: shared UART/loader constants and packer state encoding
package rx_word_packer_pkg;
  localparam int N_DATA  = 8;
  localparam int N_BYTES = 4;
  localparam int NB_WORD = N_DATA * N_BYTES;
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1
  } state_t;
endpackage

// File: rtl/rx_word_packer.sv
// rx_word_packer: packs UART receiver bytes little-endian into words for the program loader
module rx_word_packer #(
  parameter int N_DATA         = rx_word_packer_pkg::N_DATA,
  parameter int N_BYTES        = rx_word_packer_pkg::N_BYTES,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int NB_WORD        = N_DATA * N_BYTES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_DATA-1:0]  din,
  input  logic               rx_done_tick,
  input  logic               word_ready,
  input  logic               clear_err,
  output logic [NB_WORD-1:0] word,
  output logic               word_valid,
  output logic [2:0]         byte_count,
  output logic               overflow,
  output logic               timeout_err,
  output logic [1:0]         packer_state
);
  import rx_word_packer_pkg::*;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state, state_n;
  logic [NB_WORD-1:0] word_n;
  logic [2:0] bc_n, lane;
  logic [TW-1:0] tmo_cnt, cnt_n;
  logic ovf_n, terr_n, rx_prev, accept, expire;
  assign accept = rx_done_tick & ~rx_prev;
  assign expire = state == ST_COLLECT && byte_count != 3'd0 && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign word_valid = state == ST_FULL;
  assign packer_state = state;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= ST_COLLECT;
      word        <= '0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
      rx_prev     <= 1'b0;
    end else begin
      state       <= state_n;
      word        <= word_n;
      byte_count  <= bc_n;
      overflow    <= ovf_n;
      timeout_err <= terr_n;
      tmo_cnt     <= cnt_n;
      rx_prev     <= rx_done_tick;
    end
  // An expiring partial word is dropped first, so a coincident byte restarts at lane 0
  always_comb begin
    state_n = state;
    word_n  = word;
    bc_n    = byte_count;
    ovf_n   = overflow & ~clear_err;
    terr_n  = 1'b0;
    cnt_n   = tmo_cnt;
    lane    = byte_count;
    if (state == ST_COLLECT) begin
      if (expire) begin
        terr_n = 1'b1;
        bc_n   = 3'd0;
        cnt_n  = '0;
        lane   = 3'd0;
      end else if (byte_count != 3'd0) cnt_n = tmo_cnt + 1'b1;
      if (accept) begin
        cnt_n = '0;
        for (int i = 0; i < N_BYTES; i++)
          if (lane == 3'(i)) word_n[i*N_DATA +: N_DATA] = din;
        state_n = lane == 3'(N_BYTES - 1) ? ST_FULL : ST_COLLECT;
        bc_n    = lane == 3'(N_BYTES - 1) ? 3'd0 : lane + 3'd1;
      end
    end else if (word_ready) begin
      state_n = ST_COLLECT;
      if (accept) begin
        word_n[N_DATA-1:0] = din;
        bc_n  = 3'd1;
        cnt_n = '0;
      end
    end else if (accept) ovf_n = 1'b1;
  end
endmodule

// File: tb/tb_rx_word_packer.sv
// tb_rx_word_packer: directed checks of byte packing, handshake, overflow, timeout and reset
module tb_rx_word_packer;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] din = '0;
  logic rx_done_tick = 1'b0, word_ready = 1'b0, clear_err = 1'b0;
  logic [31:0] word;
  logic word_valid, overflow, timeout_err;
  logic [2:0] byte_count;
  logic [1:0] packer_state;
  int checks = 0, failures = 0;
  int seen;

  rx_word_packer #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .din(din), .rx_done_tick(rx_done_tick),
    .word_ready(word_ready), .clear_err(clear_err), .word(word),
    .word_valid(word_valid), .byte_count(byte_count), .overflow(overflow),
    .timeout_err(timeout_err), .packer_state(packer_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clock);
    din = b;
    rx_done_tick = 1'b1;
    @(negedge clock);
    rx_done_tick = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clock);
    word_ready = 1'b1;
    @(negedge clock);
    word_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_word", word, 32'h0);
    check("rst_valid", word_valid, 0);
    check("rst_count", byte_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_state", packer_state, 0);
    reset = 1'b0;

    strobe(8'h78); strobe(8'h56); strobe(8'h34);
    check("partial_count", byte_count, 3);
    check("partial_valid", word_valid, 0);
    strobe(8'h12);
    check("full_valid", word_valid, 1);
    check("full_word", word, 32'h12345678);
    check("full_count", byte_count, 0);
    check("full_state", packer_state, 1);
    handshake();
    check("hs_valid", word_valid, 0);
    check("hs_state", packer_state, 0);

    strobe(8'h78); strobe(8'h56); strobe(8'h34); strobe(8'h12);
    strobe(8'hAA);
    check("ovf_set", overflow, 1);
    check("ovf_word", word, 32'h12345678);
    check("ovf_valid", word_valid, 1);
    @(negedge clock); clear_err = 1'b1;
    @(negedge clock); clear_err = 1'b0;
    check("ovf_clear", overflow, 0);

    @(negedge clock);
    din = 8'hAA; rx_done_tick = 1'b1; word_ready = 1'b1;
    @(negedge clock);
    rx_done_tick = 1'b0; word_ready = 1'b0;
    check("hs_byte_ovf", overflow, 0);
    check("hs_byte_count", byte_count, 1);
    check("hs_byte_valid", word_valid, 0);
    strobe(8'hBB); strobe(8'hCC); strobe(8'hDD);
    check("hs_byte_word", word, 32'hDDCCBBAA);

    @(negedge clock);
    din = 8'hEE; rx_done_tick = 1'b1; clear_err = 1'b1;
    @(negedge clock);
    rx_done_tick = 1'b0; clear_err = 1'b0;
    check("ovf_vs_clear", overflow, 1);
    check("ovf_vs_clear_word", word, 32'hDDCCBBAA);
    @(negedge clock); clear_err = 1'b1;
    @(negedge clock); clear_err = 1'b0;
    check("ovf_clear2", overflow, 0);
    handshake();

    strobe(8'h01); strobe(8'h02);
    seen = 0;
    for (int i = 1; i <= 40 && seen == 0; i++) begin
      @(negedge clock);
      if (timeout_err) seen = i;
    end
    check("tmo_cycle", seen, 16);
    check("tmo_count", byte_count, 0);
    @(negedge clock);
    check("tmo_pulse_end", timeout_err, 0);
    strobe(8'hA1); strobe(8'hB2); strobe(8'hC3); strobe(8'hD4);
    check("tmo_next_valid", word_valid, 1);
    check("tmo_next_word", word, 32'hD4C3B2A1);
    handshake();

    @(negedge clock);
    din = 8'h11; rx_done_tick = 1'b1;
    repeat (5) @(negedge clock);
    rx_done_tick = 1'b0;
    check("held_count", byte_count, 1);

    strobe(8'h22); strobe(8'h33);
    check("pre_rst_count", byte_count, 3);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_count", byte_count, 0);
    check("async_word", word, 32'h0);
    check("async_valid", word_valid, 0);
    check("async_state", packer_state, 0);
    @(negedge clock);
    reset = 1'b0;
    strobe(8'h01); strobe(8'h02); strobe(8'h03);
    check("post_rst_valid", word_valid, 0);
    strobe(8'h04);
    check("post_rst_word", word, 32'h04030201);
    check("post_rst_vld", word_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_word_packer.md
RX_WORD_PACKER -- requirements
Module: rx_word_packer

Interface
REQ-001 Parameter N_DATA, default 8, width of each received byte.
REQ-002 Parameter N_BYTES, default 4, bytes per assembled word; word width NB_WORD = N_DATA*N_BYTES (32).
REQ-003 Parameter TIMEOUT_CYCLES, default 1_000_000, idle clock cycles after which a partial word is discarded.
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 din  input  N_DATA  received byte from the UART receiver's dout.
REQ-007 rx_done_tick  input  1  byte-valid strobe from the UART receiver.
REQ-008 word_ready  input  1  downstream (program loader) can accept the word.
REQ-009 clear_err  input  1  synchronous clear of the sticky overflow flag.
REQ-010 word  output  NB_WORD  assembled word, byte 0 in bits [7:0] (little-endian).
REQ-011 word_valid  output  1  word is complete and stable.
REQ-012 byte_count  output  3  bytes collected into the current partial word.
REQ-013 overflow  output  1  sticky: a byte arrived while a word was pending.
REQ-014 timeout_err  output  1  one-cycle pulse: partial word discarded on timeout.
REQ-015 packer_state  output  2  current FSM state, for debug.

Function
REQ-016 Byte accept event = rising edge of rx_done_tick (registered previous value); a strobe held high N cycles counts once.
REQ-017 FSM states: ST_COLLECT (word_valid=0), ST_FULL (word_valid=1); one-hot-free 2-bit encoding, ST_COLLECT=0, ST_FULL=1.
REQ-018 ST_COLLECT: on accept event, din written to word byte lane byte_count, byte_count increments, timeout counter clears.
REQ-019 ST_COLLECT: accept event with byte_count = N_BYTES-1 writes the last lane, byte_count returns to 0, next state ST_FULL; word_valid rises the following cycle (latency 1 clock from accept event).
REQ-020 ST_FULL: word and word_valid held stable until word_valid && word_ready; then next state ST_COLLECT.
REQ-021 ST_FULL: accept event without handshake in the same cycle drops the byte and sets overflow.
REQ-022 ST_FULL: accept event in the same cycle as handshake -> handshake completes, byte stored in lane 0, byte_count=1, no overflow.
REQ-023 Timeout counter runs only in ST_COLLECT with byte_count>0; at TIMEOUT_CYCLES-1 it clears byte_count and counter, pulses timeout_err for one cycle; word contents are don't-care.
REQ-024 Accept event in the same cycle as timeout expiry: timeout wins for the old partial word, new byte stored in lane 0, byte_count=1.
REQ-025 overflow cleared only by reset or clear_err; overflow set and clear_err in the same cycle -> overflow stays 1.
REQ-026 Timeout counter width = ceil(log2(TIMEOUT_CYCLES)); no wrap-around reachable.

Reset
REQ-027 On reset: state ST_COLLECT, word=0, word_valid=0, byte_count=0, overflow=0, timeout_err=0, timeout counter=0, edge-detect register=0.
REQ-028 Reset mid-word or in ST_FULL discards the partial/pending word; no word_valid after reset release until N_BYTES fresh accept events.

Structure
REQ-029 State encodings, N_DATA, N_BYTES and NB_WORD constants in the shared UART/loader package.
REQ-030 Single registered-state always block plus combinational next-state block; no sub-module required (edge detector inline).

Verification
REQ-031 Bytes 0x78,0x56,0x34,0x12 as single-cycle strobes -> word=0x12345678, word_valid 1 clock after 4th strobe; word_ready=1 -> word_valid=0 next cycle.
REQ-032 word_ready held 0, 5th byte 0xAA arrives -> overflow=1, word unchanged 0x12345678; clear_err pulse -> overflow=0.
REQ-033 5th byte 0xAA strobed in same cycle as word_ready=1 -> no overflow, byte_count=1, next word lane 0 = 0xAA.
REQ-034 TIMEOUT_CYCLES=16, two bytes then 16 idle cycles -> timeout_err one-cycle pulse, byte_count=0; next 4 bytes form a complete word.
REQ-035 rx_done_tick held high 5 cycles with din=0x11 -> byte_count=1 only.
REQ-036 reset asserted asynchronously after 3 bytes -> all outputs 0 immediately; 4 new bytes 0x01..0x04 -> word=0x04030201.
